line_writeback: RTL and testbench
=================================

# line_writeback

Cache-line write-back initiator on the main system bus; the write-direction counterpart of the line-fill reader. When enabled, it captures a 64-byte-aligned address and a 512-bit line, arbitrates for the bus, issues a memory-write request, and streams the line as eight 64-bit beats, lowest beat first. It sits between the data cache's eviction path and the bus arbiter, and signals `ready` once the line has left the block.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, bus beat width; the line is 8 beats
- BUS_TAG_WIDTH, 13, bus tag width

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-high; one clock
- enable  in  1  start request; sampled in IDLE or DONE
- addr  in  64  line address; bits [5:0] ignored
- data  in  512  line payload; beat i = data[64*i+63:64*i]
- abtr_grant  in  1  arbiter grant
- abtr_reqcyc  out  1  arbiter request
- bus_busy  out  1  block owns the bus
- main_bus_reqcyc  out  1  request/data beat valid
- main_bus_req  out  64  address beat, then data beats
- main_bus_reqtag  out  13  request tag
- main_bus_reqack  in  1  memory accepted the address beat
- ready  out  1  write-back complete

## Operation
- Tag constant WR = `SYSBUS_WRITE<<12 | `SYSBUS_MEMORY<<8. With the codebase defines (WRITE=0, MEMORY=1), WR = 13'h0100.
- State machine: IDLE, ARB, ADDR, DATA, DONE. All outputs are registered decodes of the current state. Beat counter is 3 bits.
- IDLE: all outputs 0.
  - enable=1 → ARB.
  - On that edge, latch addr_q = {addr[63:6], 6'b0} and line_q = data.
- ARB: abtr_reqcyc=1; all other outputs 0.
  - abtr_grant=1 → ADDR; otherwise stay in ARB.
- ADDR: bus_busy=1, main_bus_reqcyc=1, main_bus_req=addr_q, main_bus_reqtag=WR.
  - Hold all of these until main_bus_reqack=1, then → DATA with beat=0.
- DATA: bus_busy=1, main_bus_reqcyc=1, main_bus_reqtag=WR, main_bus_req=line_q[64*beat +: 64].
  - beat increments every cycle; no back-pressure.
  - beat==7 → DONE.
- DONE: ready=1, bus_busy=0; all bus outputs 0.
  - Stay in DONE until enable=1.
  - enable=1 → ARB, relatch addr and data, ready drops.
- Ignored inputs:
  - enable in ARB, ADDR or DATA.
  - abtr_grant outside ARB.
  - main_bus_reqack outside ADDR.
- Latched addr/data are immune to input changes after capture.

## Timing
- Reset (asynchronous): state=IDLE, beat=0, and every output is 0 immediately, without waiting for a clock edge.
  - Reset mid-transfer abandons the transfer; no further beats are driven.
  - Deassertion takes effect at the next posedge.
- Minimum latency, with grant and reqack already high when sampled:
  - Edge 0: enable sampled.
  - Cycle 1: ARB.
  - Cycle 2: ADDR.
  - Cycles 3–10: data beats 0–7.
  - Cycle 11: ready=1.
- Each cycle that grant or reqack is absent adds exactly one cycle.
- bus_busy is high exactly from the first ADDR cycle through the last DATA cycle.
- main_bus_reqcyc is never high outside ADDR/DATA.
- Data beats are on consecutive cycles with no gaps.
- abtr_reqcyc and bus_busy are never both high.

## Test plan
- Basic write:
  - Stimulus: addr=64'h1234_5678_9ABC_DEF7, data beat i = 64'hA0+i; grant and reqack held high.
  - Required: cycle 2 req=64'h1234_5678_9ABC_DEC0 with tag 13'h0100; cycles 3–10 req=A0..A7, reqcyc=1; cycle 11 ready=1.
- Grant delay:
  - Stimulus: grant withheld for 5 cycles.
  - Required: abtr_reqcyc high 6 cycles, bus outputs 0 throughout; ready at cycle 16.
- Reqack stall:
  - Stimulus: reqack low for 3 ADDR cycles.
  - Required: address/tag/reqcyc held stable 4 cycles; beats then 8 consecutive cycles.
- Input mutation:
  - Stimulus: change addr/data and pulse enable during DATA.
  - Required: original beats sent; no restart.
- Async reset mid-DATA:
  - Stimulus: assert reset between edges after beat 3.
  - Required: all outputs 0 before the next edge; after release, IDLE and no beats until a new enable.
- Back-to-back:
  - Stimulus: enable held high in DONE.
  - Required: ready high one cycle, then ARB; second line written with newly latched addr/data.

Source files
------------

// File: rtl/line_writeback_if.sv
// Bus-side signal bundle for the cache-line write-back initiator: the
// arbiter handshake plus the main system bus request channel.
interface line_writeback_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      abtr_grant;
  logic                      abtr_reqcyc;
  logic                      bus_busy;
  logic                      main_bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] main_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag;
  logic                      main_bus_reqack;

  // The write-back block drives requests and sees grant/acknowledge.
  modport master (
    input  abtr_grant,
    input  main_bus_reqack,
    output abtr_reqcyc,
    output bus_busy,
    output main_bus_reqcyc,
    output main_bus_req,
    output main_bus_reqtag
  );

  // Arbiter / memory side of the same bundle.
  modport slave (
    output abtr_grant,
    output main_bus_reqack,
    input  abtr_reqcyc,
    input  bus_busy,
    input  main_bus_reqcyc,
    input  main_bus_req,
    input  main_bus_reqtag
  );
endinterface

// File: rtl/line_writeback.sv
// Cache-line write-back initiator. Captures a 64-byte-aligned address and a
// full line, wins the bus through the arbiter, sends one address beat and
// then eight data beats (lowest first), and raises ready when done.
// Outputs depend only on registered state, so an asynchronous reset clears
// them immediately.
module line_writeback #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [63:0]                 addr,
  input  logic [8*BUS_DATA_WIDTH-1:0] data,
  output logic                        ready,
  line_writeback_if.master            bus
);

  localparam int SYSBUS_WRITE  = 0;
  localparam int SYSBUS_MEMORY = 1;
  localparam logic [BUS_TAG_WIDTH-1:0] WR_TAG =
    BUS_TAG_WIDTH'((SYSBUS_WRITE << 12) | (SYSBUS_MEMORY << 8));

  // Clearing the low six bits aligns the address to the 64-byte line.
  localparam logic [63:0] LINE_ADDR_MASK = ~64'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                      state_reg, state_next;
  logic [2:0]                  beat_reg, beat_next;
  logic [63:0]                 addr_reg;
  logic [8*BUS_DATA_WIDTH-1:0] line_reg;
  logic                        capture;
  logic [BUS_DATA_WIDTH-1:0]   beat_word [8];

  // A new line is only accepted when no transfer is in flight.
  assign capture = enable && (state_reg == S_IDLE || state_reg == S_DONE);

  // Split the latched line into its eight bus beats.
  for (genvar gi = 0; gi < 8; gi++) begin : g_beat
    assign beat_word[gi] = line_reg[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
  end

  // State, beat counter and captured line/address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      beat_reg  <= 3'd0;
      addr_reg  <= '0;
      line_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (capture) begin
        addr_reg <= addr & LINE_ADDR_MASK;
        line_reg <= data;
      end
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next          = state_reg;
    beat_next           = beat_reg;
    ready               = 1'b0;
    bus.abtr_reqcyc     = 1'b0;
    bus.bus_busy        = 1'b0;
    bus.main_bus_reqcyc = 1'b0;
    bus.main_bus_req    = '0;
    bus.main_bus_reqtag = '0;
    case (state_reg)
      S_IDLE: begin
        if (enable) state_next = S_ARB;
      end
      S_ARB: begin
        bus.abtr_reqcyc = 1'b1;
        if (bus.abtr_grant) state_next = S_ADDR;
      end
      S_ADDR: begin
        bus.bus_busy        = 1'b1;
        bus.main_bus_reqcyc = 1'b1;
        bus.main_bus_req    = BUS_DATA_WIDTH'(addr_reg);
        bus.main_bus_reqtag = WR_TAG;
        beat_next           = 3'd0;
        if (bus.main_bus_reqack) state_next = S_DATA;
      end
      S_DATA: begin
        // Memory takes one beat per cycle; there is no back-pressure.
        bus.bus_busy        = 1'b1;
        bus.main_bus_reqcyc = 1'b1;
        bus.main_bus_req    = beat_word[beat_reg];
        bus.main_bus_reqtag = WR_TAG;
        beat_next           = beat_reg + 3'd1;
        if (beat_reg == 3'd7) state_next = S_DONE;
      end
      S_DONE: begin
        ready = 1'b1;
        if (enable) state_next = S_ARB;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_line_writeback.sv
// Directed bench for line_writeback: basic write, grant delay, reqack stall,
// input mutation during DATA, async reset mid-transfer, back-to-back lines.
module tb_line_writeback;

  localparam logic [63:0] WR = 64'h0100;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [63:0]  addr;
  logic [511:0] data;
  logic         ready;

  int n_checks;
  int n_fail;

  line_writeback_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bus ();

  line_writeback #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .addr   (addr),
    .data   (data),
    .ready  (ready),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_line(input logic [63:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[64*i +: 64] = base + 64'(i);
    return l;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".ready"},   64'(ready), 64'd0);
    check({tag, ".abtr"},    64'(bus.abtr_reqcyc), 64'd0);
    check({tag, ".busy"},    64'(bus.bus_busy), 64'd0);
    check({tag, ".reqcyc"},  64'(bus.main_bus_reqcyc), 64'd0);
    check({tag, ".req"},     bus.main_bus_req, 64'd0);
    check({tag, ".tag"},     64'(bus.main_bus_reqtag), 64'd0);
  endtask

  // Present a line and sample enable on the next edge; returns in cycle 1.
  task automatic start(input logic [63:0] a, input logic [63:0] base);
    addr   = a;
    data   = make_line(base);
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  // Follow one transfer from cycle 1 to the ready cycle.
  task automatic expect_write(input string tag, input logic [63:0] exp_addr,
                              input logic [63:0] base, input int gnt_wait,
                              input int ack_wait, input int exp_ready_cyc,
                              input bit mutate);
    int cyc;
    cyc = 1;
    for (int k = 0; k <= gnt_wait; k++) begin
      bus.abtr_grant = (k == gnt_wait);
      check({tag, ".arb.abtr"},   64'(bus.abtr_reqcyc), 64'd1);
      check({tag, ".arb.busy"},   64'(bus.bus_busy), 64'd0);
      check({tag, ".arb.reqcyc"}, 64'(bus.main_bus_reqcyc), 64'd0);
      check({tag, ".arb.req"},    bus.main_bus_req, 64'd0);
      tick();
      cyc++;
    end
    for (int k = 0; k <= ack_wait; k++) begin
      bus.main_bus_reqack = (k == ack_wait);
      check({tag, ".addr.req"},    bus.main_bus_req, exp_addr);
      check({tag, ".addr.tag"},    64'(bus.main_bus_reqtag), WR);
      check({tag, ".addr.reqcyc"}, 64'(bus.main_bus_reqcyc), 64'd1);
      check({tag, ".addr.busy"},   64'(bus.bus_busy), 64'd1);
      check({tag, ".addr.abtr"},   64'(bus.abtr_reqcyc), 64'd0);
      tick();
      cyc++;
    end
    for (int i = 0; i < 8; i++) begin
      bus.main_bus_reqack = 1'b0;
      check({tag, ".data.req"},    bus.main_bus_req, base + 64'(i));
      check({tag, ".data.reqcyc"}, 64'(bus.main_bus_reqcyc), 64'd1);
      check({tag, ".data.busy"},   64'(bus.bus_busy), 64'd1);
      check({tag, ".data.tag"},    64'(bus.main_bus_reqtag), WR);
      check({tag, ".data.ready"},  64'(ready), 64'd0);
      if (mutate && i == 2) begin
        addr   = 64'hFFFF_0000_FFFF_0000;
        data   = make_line(64'hDEAD_0000);
        enable = 1'b1;
      end else begin
        enable = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.main_bus_reqack = 1'b1;
    check({tag, ".done.ready"},  64'(ready), 64'd1);
    check({tag, ".done.busy"},   64'(bus.bus_busy), 64'd0);
    check({tag, ".done.reqcyc"}, 64'(bus.main_bus_reqcyc), 64'd0);
    check({tag, ".done.req"},    bus.main_bus_req, 64'd0);
    check({tag, ".done.cycle"},  64'(cyc), 64'(exp_ready_cyc));
    $display("line %s: addr %h base %h ready at cycle %0d", tag, exp_addr, base, cyc);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    addr     = '0;
    data     = '0;
    bus.abtr_grant      = 1'b1;
    bus.main_bus_reqack = 1'b1;
    #1;
    check_quiet("reset");
    tick();
    reset = 1'b0;
    tick();
    check_quiet("idle");

    // Basic write with grant and reqack already high.
    start(64'h1234_5678_9ABC_DEF7, 64'hA0);
    expect_write("basic", 64'h1234_5678_9ABC_DEC0, 64'hA0, 0, 0, 11, 1'b0);
    tick();
    check("basic.hold_done", 64'(ready), 64'd1);

    // Grant withheld for five cycles.
    bus.abtr_grant = 1'b0;
    start(64'h0000_0000_0000_1040, 64'h1000);
    expect_write("gnt", 64'h0000_0000_0000_1040, 64'h1000, 5, 0, 16, 1'b0);

    // Reqack low for three ADDR cycles.
    start(64'hFEDC_BA98_7654_32FF, 64'h2000);
    expect_write("ack", 64'hFEDC_BA98_7654_32C0, 64'h2000, 0, 3, 14, 1'b0);

    // Inputs change and enable pulses during DATA; no effect.
    start(64'h0000_0000_ABCD_0080, 64'h3000);
    expect_write("mut", 64'h0000_0000_ABCD_0080, 64'h3000, 0, 0, 11, 1'b1);
    tick();
    check("mut.no_restart", 64'(ready), 64'd1);
    check("mut.no_arb", 64'(bus.abtr_reqcyc), 64'd0);

    // Asynchronous reset between edges after beat 3.
    start(64'h0000_0000_0000_0400, 64'h4000);
    tick(); tick();           // ARB, ADDR
    tick(); tick(); tick();   // beats 0..2
    check("rst.beat3", bus.main_bus_req, 64'h4003);
    #3;
    reset = 1'b1;
    #1;
    check_quiet("rst.async");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_quiet("rst.after");
    end
    start(64'h0000_0000_0000_0500, 64'h5000);
    expect_write("rst.new", 64'h0000_0000_0000_0500, 64'h5000, 0, 0, 11, 1'b0);

    // Back-to-back: enable high in DONE relaunches with new line.
    addr   = 64'h0000_0000_0000_067F;
    data   = make_line(64'h6000);
    enable = 1'b1;
    tick();
    check("b2b.ready_drop", 64'(ready), 64'd0);
    check("b2b.arb", 64'(bus.abtr_reqcyc), 64'd1);
    enable = 1'b0;
    expect_write("b2b", 64'h0000_0000_0000_0640, 64'h6000, 0, 0, 11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
